// File: rtl/delay_cal.sv
// Read-capture delay calibration: sweeps PLL fine-delay taps 0..15, tests each tap and parks the delay at the centre of the widest passing window.
// Optional manual override enabled by defining DELAY_CAL_MANUAL_EN (adds man_en/man_delay).
module delay_cal #(
    parameter logic [3:0]  DEFAULT_DELAY = 4'd8,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned N_PASS        = 2,
    parameter int unsigned MIN_WIN       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cal_start,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_ok,
    output logic [3:0]  delay,
    output logic        test_req,
    input  logic        test_done,
    input  logic        test_pass,
    output logic [15:0] pass_map,
    output logic [4:0]  win_len
`ifdef DELAY_CAL_MANUAL_EN
    ,
    input  logic        man_en,
    input  logic [3:0]  man_delay
`endif
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SET, SETTLE, TEST, EVAL, DONE} state_t;

    state_t          state, state_nx;
    logic [3:0]      tap;
    logic [SW-1:0]   settle_cnt;
    logic [3:0]      run_cnt;
    logic            tap_ok;
    logic [3:0]      idx;
    logic [3:0]      run_start, best_start;
    logic [4:0]      run_len, best_len;
    logic            last_run;
    logic            man_active;
    logic            bit_pass;
    logic [4:0]      run_len_nx;
    logic [3:0]      run_start_nx;
    logic [3:0]      centre;

`ifdef DELAY_CAL_MANUAL_EN
    logic            man_en_q;
    logic [3:0]      cal_delay;
    assign man_active = man_en;
`else
    assign man_active = 1'b0;
`endif

    assign last_run = (run_cnt == 4'(N_PASS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cal_start && !man_active) state_nx = SET;
            SET:     state_nx = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_nx = TEST;
            TEST:    if (test_req && test_done && last_run)
                         state_nx = (tap == 4'd15) ? EVAL : SET;
            EVAL:    if (idx == 4'd15) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Window scan: a run starts on a pass following a fail (or bit 0); no wrap from bit 15 to bit 0
    always_comb begin
        bit_pass     = pass_map[idx];
        run_len_nx   = bit_pass ? run_len + 5'd1 : '0;
        run_start_nx = (bit_pass && run_len == '0) ? idx : run_start;
        centre       = best_start + 4'((best_len - 5'd1) >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay      <= DEFAULT_DELAY;
            cal_busy   <= 1'b0;
            cal_done   <= 1'b0;
            cal_ok     <= 1'b0;
            test_req   <= 1'b0;
            pass_map   <= '0;
            win_len    <= '0;
            tap        <= '0;
            settle_cnt <= '0;
            run_cnt    <= '0;
            tap_ok     <= 1'b0;
            idx        <= '0;
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
`ifdef DELAY_CAL_MANUAL_EN
            man_en_q   <= 1'b0;
            cal_delay  <= DEFAULT_DELAY;
`endif
        end else begin
            cal_done <= 1'b0;
`ifdef DELAY_CAL_MANUAL_EN
            man_en_q <= man_en;
`endif
            case (state)
                IDLE: begin
`ifdef DELAY_CAL_MANUAL_EN
                    if (man_en)        delay <= man_delay;
                    else if (man_en_q) delay <= cal_delay;
`endif
                    if (cal_start && !man_active) begin
                        tap      <= '0;
                        pass_map <= '0;
                        win_len  <= '0;
                        cal_ok   <= 1'b0;
                        cal_busy <= 1'b1;
                    end
                end
                SET: begin
                    delay      <= tap;
                    settle_cnt <= SW'(SETTLE_CYCLES);
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        run_cnt <= '0;
                        tap_ok  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                TEST: begin
                    // Requests only rise from a low cycle, giving the mandatory gap between runs
                    if (!test_req) begin
                        test_req <= 1'b1;
                    end else if (test_done) begin
                        test_req <= 1'b0;
                        tap_ok   <= tap_ok & test_pass;
                        run_cnt  <= run_cnt + 4'd1;
                        if (last_run) begin
                            pass_map[tap] <= tap_ok & test_pass;
                            if (tap != 4'd15) begin
                                tap <= tap + 4'd1;
                            end else begin
                                idx        <= '0;
                                run_start  <= '0;
                                run_len    <= '0;
                                best_start <= '0;
                                best_len   <= '0;
                            end
                        end
                    end
                end
                EVAL: begin
                    run_len   <= run_len_nx;
                    run_start <= run_start_nx;
                    if (run_len_nx > best_len) begin
                        best_len   <= run_len_nx;
                        best_start <= run_start_nx;
                    end
                    idx <= idx + 4'd1;
                end
                DONE: begin
                    win_len  <= best_len;
                    cal_done <= 1'b1;
                    cal_busy <= 1'b0;
                    if (best_len >= 5'(MIN_WIN)) begin
                        delay  <= centre;
                        cal_ok <= 1'b1;
`ifdef DELAY_CAL_MANUAL_EN
                        cal_delay <= centre;
`endif
                    end else begin
                        delay  <= DEFAULT_DELAY;
                        cal_ok <= 1'b0;
`ifdef DELAY_CAL_MANUAL_EN
                        cal_delay <= DEFAULT_DELAY;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_cal.sv
// Scoreboard bench for delay_cal: directed pass patterns drive a behavioural test engine; a monitor checks results at each cal_done.
module tb_delay_cal;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cal_start;
    logic        cal_busy, cal_done, cal_ok;
    logic [3:0]  delay;
    logic        test_req;
    logic        test_done, test_pass;
    logic [15:0] pass_map;
    logic [4:0]  win_len;
    logic        man_en;
    logic [3:0]  man_delay;

    always #5 clk = ~clk;

    delay_cal #(
        .DEFAULT_DELAY(4'd8),
        .SETTLE_CYCLES(64),
        .N_PASS(2),
        .MIN_WIN(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cal_start(cal_start),
        .cal_busy(cal_busy),
        .cal_done(cal_done),
        .cal_ok(cal_ok),
        .delay(delay),
        .test_req(test_req),
        .test_done(test_done),
        .test_pass(test_pass),
        .pass_map(pass_map),
        .win_len(win_len)
`ifdef DELAY_CAL_MANUAL_EN
        ,
        .man_en(man_en),
        .man_delay(man_delay)
`endif
    );

    typedef struct {
        logic [15:0] map;
        logic [4:0]  wl;
        logic [3:0]  dly;
        logic        ok;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] pat = '0;
    int          fail_tap = -1;
    int          hs = 0;
    bit          spurious = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory test engine model: answers each request after 3 cycles
    initial begin
        int lat;
        lat = 0;
        test_done = 1'b0;
        test_pass = 1'b0;
        forever begin
            @(negedge clk);
            test_done = 1'b0;
            test_pass = 1'b0;
            if (!rst_n) begin
                lat = 0;
            end else if (test_req) begin
                lat++;
                if (lat == 3) begin
                    check("test_delay", 32'(delay), 32'(hs / 2));
                    test_pass = pat[delay] && !(int'(delay) == fail_tap && (hs % 2) == 1);
                    test_done = 1'b1;
                    hs++;
                    lat = 0;
                end
            end else begin
                lat = 0;
                if (spurious) begin
                    test_done = 1'b1;
                    spurious  = 0;
                end
            end
        end
    end

    // Monitor: settle spacing and result scoreboard
    initial begin
        logic [3:0] prev_delay;
        logic       prev_req;
        int         since;
        exp_t       e;
        prev_delay = 'x;
        prev_req   = 1'b0;
        since      = 0;
        forever begin
            @(negedge clk);
            if (rst_n && test_req && !prev_req && cal_busy)
                check("settle_gap", 32'(since >= 64), 32'd1);
            if (delay !== prev_delay) since = 0;
            else                      since++;
            prev_delay = delay;
            prev_req   = test_req;
            if (rst_n && cal_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got cal_done=1 expected no pulse");
                end else begin
                    e = sb.pop_front();
                    check("pass_map", 32'(pass_map), 32'(e.map));
                    check("win_len", 32'(win_len), 32'(e.wl));
                    check("delay", 32'(delay), 32'(e.dly));
                    check("cal_ok", 32'(cal_ok), 32'(e.ok));
                    check("busy_at_done", 32'(cal_busy), 32'd0);
                    check("handshakes", 32'(hs), 32'd32);
                end
            end
        end
    end

    task automatic run_cal(input logic [15:0] p, input int ft, input logic [15:0] emap,
                           input logic [4:0] ewl, input logic [3:0] ed, input logic eok,
                           input bit disturb);
        exp_t e;
        int   n;
        pat      = p;
        fail_tap = ft;
        hs       = 0;
        e.map = emap; e.wl = ewl; e.dly = ed; e.ok = eok;
        sb.push_back(e);
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        check("busy_after_start", 32'(cal_busy), 32'd1);
        n = 0;
        if (disturb) begin
            repeat (200) @(negedge clk);
            cal_start = 1'b1;
            spurious  = 1;
            @(negedge clk) cal_start = 1'b0;
            repeat (300) @(negedge clk);
            spurious = 1;
            n = 501;
        end
        while (!cal_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cal_done) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clk);
        check("single_done", 32'(cal_done), 32'd0);
    endtask

    initial begin
        int n;
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        cal_start = 1'b0;
        man_en    = 1'b0;
        man_delay = '0;
        repeat (3) @(negedge clk);
        check("rst_delay", 32'(delay), 32'd8);
        check("rst_busy", 32'(cal_busy), 32'd0);
        check("rst_req", 32'(test_req), 32'd0);
        check("rst_map", 32'(pass_map), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_cal(16'h0FE0, -1, 16'h0FE0, 5'd7,  4'd8, 1'b1, 0);
        run_cal(16'h0E0E, -1, 16'h0E0E, 5'd3,  4'd2, 1'b1, 0);
        run_cal(16'h0000, -1, 16'h0000, 5'd0,  4'd8, 1'b0, 0);
        run_cal(16'hFFFF, -1, 16'hFFFF, 5'd16, 4'd7, 1'b1, 0);
        run_cal(16'h8003, -1, 16'h8003, 5'd2,  4'd8, 1'b0, 0);
        run_cal(16'h0FE0,  6, 16'h0FA0, 5'd5,  4'd9, 1'b1, 0);
        run_cal(16'h0FE0, -1, 16'h0FE0, 5'd7,  4'd8, 1'b1, 1);

        // Abort mid-sweep once the delay reaches tap 9
        pat = 16'h0FE0; fail_tap = -1; hs = 0;
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        n = 0;
        while (delay != 4'd9 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach_tap9", 32'(delay), 32'd9);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_delay", 32'(delay), 32'd8);
        check("abort_busy", 32'(cal_busy), 32'd0);
        check("abort_done", 32'(cal_done), 32'd0);
        check("abort_ok", 32'(cal_ok), 32'd0);
        check("abort_req", 32'(test_req), 32'd0);
        check("abort_map", 32'(pass_map), 32'd0);
        check("abort_win", 32'(win_len), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_cal(16'h0E0E, -1, 16'h0E0E, 5'd3, 4'd2, 1'b1, 0);

`ifdef DELAY_CAL_MANUAL_EN
        man_en = 1'b1; man_delay = 4'd3;
        @(negedge clk);
        check("man_delay", 32'(delay), 32'd3);
        cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        check("man_start_ignored", 32'(cal_busy), 32'd0);
        man_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("man_restore", 32'(delay), 32'd2);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
